mtl_vblank_cmd_scheduler: RTL

//  Queues game/map commands written by the NIOS side and issues them to the Qbert map/colour engine.

---
 rtl/mtl_vblank_cmd_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mtl_vblank_cmd_scheduler.sv
// Vertical-blank command scheduler: buffers NIOS commands and hands them to the Qbert engine only
// between iEndFrame and iNewFrame. Optional MTL_CMDQ_STATS_EN adds issued/missed-window counters.
module mtl_vblank_cmd_scheduler #(
    parameter int DEPTH         = 8,
    parameter int MAX_PER_FRAME = 4,
    parameter int TIMEOUT       = 4095
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    input  logic                     iCmd_valid,
    input  logic [31:0]              iCmd_data,
    output logic                     oCmd_ready,
    input  logic                     iNewFrame,
    input  logic                     iEndFrame,
    output logic                     oIssue_valid,
    output logic [3:0]               oIssue_op,
    output logic [27:0]              oIssue_arg,
    input  logic                     iIssue_ack,
    input  logic                     iDone,
    input  logic                     iClear,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oBusy,
    output logic                     oOverflow,
    output logic                     oTimeout,
    output logic [15:0]              oIssued_cnt,
    output logic [15:0]              oMissed_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_FENCE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WINDOW,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t         state_q;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic [3:0]     count_q;
    logic [15:0]    timer_q;
    logic           win_q;
    logic           issue_valid_q;
    logic [3:0]     issue_op_q;
    logic [27:0]    issue_arg_q;
    logic           overflow_q, timeout_q;

    logic           full, empty;
    logic [31:0]    head;
    logic [3:0]     head_op;
    logic           count_max, timer_hit;
    logic           ctrl_pop, fence_pop, accept, pop, push;
    logic           win_close_local, win_next;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign head      = mem[rd_ptr_q];
    assign head_op   = head[31:28];
    assign count_max = (count_q == 4'(MAX_PER_FRAME));
    assign timer_hit = (timer_q == 16'(TIMEOUT));

    // NOP and FENCE never reach the engine; they are consumed straight from the head in WINDOW.
    assign ctrl_pop  = (state_q == S_WINDOW) && !iNewFrame && !count_max && !iClear && !empty &&
                       ((head_op == OP_NOP) || (head_op == OP_FENCE));
    assign fence_pop = ctrl_pop && (head_op == OP_FENCE);
    assign accept    = (state_q == S_ISSUE) && iIssue_ack && !iClear;
    assign pop       = ctrl_pop || accept;
    assign push      = iCmd_valid && !full && !iClear;

    assign win_close_local = (state_q == S_WINDOW) && !iNewFrame && (count_max || fence_pop);
    assign win_next        = iNewFrame       ? 1'b0 :
                             win_close_local ? 1'b0 :
                             iEndFrame       ? 1'b1 : win_q;

    assign oCmd_ready   = !full;
    assign oLevel       = level_q;
    assign oBusy        = (state_q != S_IDLE) || !empty;
    assign oIssue_valid = issue_valid_q;
    assign oIssue_op    = issue_op_q;
    assign oIssue_arg   = issue_arg_q;
    assign oOverflow    = overflow_q;
    assign oTimeout     = timeout_q;

    // NOTE: the storage array has no reset; entries are only ever read below the write pointer,
    // so resetting it would just cost a reset net per bit.
    always_ff @(posedge iCLK) begin
        if (push)
            mem[wr_ptr_q] <= iCmd_data;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (iClear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (pop && !push)
                level_q <= level_q - 1'b1;
            if (iCmd_valid && full)
                overflow_q <= 1'b1;
        end
    end

    // NOTE: all state here is assigned with <= so every branch sees the pre-edge values;
    // a later assignment in the same block overrides an earlier one (used for flag clearing).
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            timer_q       <= '0;
            win_q         <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_arg_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            win_q <= win_next;
            if (iClear)
                timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iEndFrame && !iNewFrame) begin
                        state_q <= S_WINDOW;
                        count_q <= '0;
                    end
                end
                S_WINDOW: begin
                    if (iNewFrame || count_max) begin
                        state_q <= S_IDLE;
                    end else if (!iClear && !empty) begin
                        if (head_op == OP_FENCE) begin
                            state_q <= S_IDLE;
                        end else if (head_op != OP_NOP) begin
                            state_q       <= S_ISSUE;
                            issue_valid_q <= 1'b1;
                            issue_op_q    <= head_op;
                            issue_arg_q   <= head[27:0];
                        end
                    end
                end
                S_ISSUE: begin
                    if (iClear) begin
                        state_q       <= S_IDLE;
                        issue_valid_q <= 1'b0;
                    end else if (iIssue_ack) begin
                        state_q       <= S_WAIT_DONE;
                        issue_valid_q <= 1'b0;
                        timer_q       <= '0;
                        if (count_q != 4'hF)
                            count_q <= count_q + 1'b1;
                    end else if (iNewFrame) begin
                        state_q       <= S_IDLE;
                        issue_valid_q <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    // A frame may start and end while the engine is still busy; the new window
                    // gets a fresh issue budget.
                    if (iEndFrame && !iNewFrame)
                        count_q <= '0;
                    if (iDone || timer_hit) begin
                        if (!iDone && !iClear)
                            timeout_q <= 1'b1;
                        state_q <= win_next ? S_WINDOW : S_IDLE;
                    end else if (timer_q != 16'hFFFF) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MTL_CMDQ_STATS_EN
    logic        missed_evt;
    logic [15:0] issued_q, missed_q;

    // A window counts as missed when it closes with work still queued after this cycle's pop.
    assign missed_evt = ((win_q && iNewFrame) || win_close_local) &&
                        (level_q != LW'(pop)) && !iClear;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            issued_q <= '0;
            missed_q <= '0;
        end else if (iClear) begin
            issued_q <= '0;
            missed_q <= '0;
        end else begin
            if (accept)
                issued_q <= issued_q + 1'b1;
            if (missed_evt)
                missed_q <= missed_q + 1'b1;
        end
    end

    assign oIssued_cnt = issued_q;
    assign oMissed_cnt = missed_q;
`else
    assign oIssued_cnt = '0;
    assign oMissed_cnt = '0;
`endif

endmodule
